// File: rtl/melay_pattern_gen.sv
// Serial stimulus source for a 1010 Mealy detector: shifts a captured pattern out MSB-first,
// with optional repeats separated by idle gaps, plus a golden Mealy model of the emitted line.
module melay_pattern_gen #(
    parameter int MAX_LEN = 16,
    parameter int GAP     = 2,
    parameter int OVERLAP = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [MAX_LEN-1:0]             pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   len,
    input  logic [3:0]                     repeat_cnt,
    output logic                           bit_out,
    output logic                           bit_valid,
    output logic                           busy,
    output logic                           done,
    output logic                           expect_hit
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam logic [1:0] M_S0 = 2'd0;
    localparam logic [1:0] M_S1 = 2'd1;
    localparam logic [1:0] M_S2 = 2'd2;
    localparam logic [1:0] M_S3 = 2'd3;

    logic [1:0]         r_state;
    logic [MAX_LEN-1:0] r_pat;
    logic [LW-1:0]      r_len;
    logic [IW-1:0]      r_idx;
    logic [3:0]         r_copies;
    logic [GW-1:0]      r_gap;
    logic               r_bit_out;
    logic               r_bit_valid;
    logic               r_busy;
    logic               r_done;
    logic [1:0]         r_model;

    logic [LW-1:0]      w_len_c;
    logic [IW-1:0]      w_load_idx;
    logic [IW-1:0]      w_reload_idx;

    assign w_len_c      = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
    assign w_load_idx   = IW'(w_len_c - LW'(1));
    assign w_reload_idx = IW'(r_len - LW'(1));

    // Outputs are registered one edge behind the state; FIN therefore spans two cycles
    // (first edge raises done, second edge clears it and returns to IDLE).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_pat       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_copies    <= '0;
            r_gap       <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bit_out   <= 1'b0;
                    r_bit_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    if (start) begin
                        r_pat    <= pattern;
                        r_len    <= w_len_c;
                        r_copies <= repeat_cnt;
                        r_idx    <= w_load_idx;
                        r_state  <= (w_len_c == '0) ? ST_FIN : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_bit_out   <= r_pat[r_idx];
                    r_bit_valid <= 1'b1;
                    r_busy      <= 1'b1;
                    if (r_idx == '0) begin
                        if (r_copies != '0) begin
                            r_copies <= r_copies - 4'd1;
                            if (GAP == 0) begin
                                r_idx <= w_reload_idx;
                            end else begin
                                r_gap   <= GW'(GAP - 1);
                                r_state <= ST_GAP;
                            end
                        end else begin
                            r_state <= ST_FIN;
                        end
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                ST_GAP: begin
                    r_bit_out   <= 1'b0;
                    r_bit_valid <= 1'b0;
                    r_busy      <= 1'b1;
                    if (r_gap == '0) begin
                        r_idx   <= w_reload_idx;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                default: begin
                    r_bit_out   <= 1'b0;
                    r_bit_valid <= 1'b0;
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_done <= 1'b1;
                        r_busy <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Golden detector consumes the line every clock, so history spans idle time and commands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_model <= M_S0;
        end else begin
            case (r_model)
                M_S0:    r_model <= r_bit_out ? M_S1 : M_S0;
                M_S1:    r_model <= r_bit_out ? M_S1 : M_S2;
                M_S2:    r_model <= r_bit_out ? M_S3 : M_S0;
                default: r_model <= r_bit_out ? M_S1 : ((OVERLAP != 0) ? M_S2 : M_S0);
            endcase
        end
    end

    assign expect_hit = (r_model == M_S3) && !r_bit_out;
    assign bit_out    = r_bit_out;
    assign bit_valid  = r_bit_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_melay_pattern_gen.sv
// Bench for melay_pattern_gen: per-cycle reference model of the line plus directed
// vector table, busy/reset corner sequences and randomized commands.
module tb_melay_pattern_gen;

    localparam int MAX_LEN = 16;
    localparam int GAP     = 2;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   pattern = '0;
    logic [LW-1:0] len = '0;
    logic [3:0]    repeat_cnt = '0;

    logic a_bit, a_valid, a_busy, a_done, a_hit;
    logic b_bit, b_valid, b_busy, b_done, b_hit;

    melay_pattern_gen #(.MAX_LEN(MAX_LEN), .GAP(GAP), .OVERLAP(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
        .repeat_cnt(repeat_cnt), .bit_out(a_bit), .bit_valid(a_valid),
        .busy(a_busy), .done(a_done), .expect_hit(a_hit)
    );

    melay_pattern_gen #(.MAX_LEN(MAX_LEN), .GAP(GAP), .OVERLAP(0)) u_dut_no (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
        .repeat_cnt(repeat_cnt), .bit_out(b_bit), .bit_valid(b_valid),
        .busy(b_busy), .done(b_done), .expect_hit(b_hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic v;
        logic bsy;
        logic dn;
    } exp_t;

    typedef struct {
        logic [15:0] pat;
        logic [4:0]  len;
        logic [3:0]  rep;
        int          nbits;
        int          t_done;
        int          hov;
        int          hno;
    } vec_t;

    exp_t exp_q[$];
    logic line_q[$];
    int   last_hit_no = -100;
    logic cur_bit = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // A hit is the line's last four bits reading 1010, current bit included.
    function automatic logic hit_ov_f(input logic c);
        int n;
        n = line_q.size();
        if (n < 3) return 1'b0;
        return line_q[n-3] && !line_q[n-2] && line_q[n-1] && !c;
    endfunction

    // Non-overlapping: the 1010 window must lie entirely after the previous hit bit.
    function automatic logic hit_no_f(input logic c);
        return hit_ov_f(c) && ((line_q.size() - last_hit_no) >= 4);
    endfunction

    task automatic push_run(input logic [15:0] p, input logic [4:0] l, input logic [3:0] r);
        int lc;
        lc = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
        if (lc != 0) begin
            for (int c = 0; c <= int'(r); c++) begin
                for (int k = 0; k < lc; k++) exp_q.push_back({p[lc-1-k], 1'b1, 1'b1, 1'b0});
                if (c < int'(r))
                    for (int g = 0; g < GAP; g++) exp_q.push_back(4'b0010);
            end
        end
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0000);
    endtask

    task automatic step();
        logic        acc;
        logic [15:0] cp;
        logic [4:0]  cl;
        logic [3:0]  cr;
        exp_t        e;
        acc = rst && start && (exp_q.size() == 0);
        cp = pattern;
        cl = len;
        cr = repeat_cnt;
        @(posedge clk);
        if (rst) begin
            if (hit_no_f(cur_bit)) last_hit_no = line_q.size();
            line_q.push_back(cur_bit);
        end
        #1;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0000;
        cur_bit = e.b;
        chk("bit_out",   a_bit,   e.b);
        chk("bit_valid", a_valid, e.v);
        chk("busy",      a_busy,  e.bsy);
        chk("done",      a_done,  e.dn);
        chk("hit_ov",    a_hit,   hit_ov_f(cur_bit));
        chk("hit_no",    b_hit,   hit_no_f(cur_bit));
        if (acc) push_run(cp, cl, cr);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
        chk("drain_idle", exp_q.size(), 0);
    endtask

    task automatic do_run(input vec_t v, input int id);
        int cnt, nb, hov, hno;
        cnt = 0; nb = 0; hov = 0; hno = 0;
        drain();
        pattern = v.pat;
        len = v.len;
        repeat_cnt = v.rep;
        start = 1'b1;
        step();
        start = 1'b0;
        pattern = ~v.pat;
        len = 5'd9;
        repeat_cnt = 4'd5;
        while (cnt < 200) begin
            step();
            cnt++;
            if (a_valid) nb++;
            if (a_hit) hov++;
            if (b_hit) hno++;
            if (a_done) break;
        end
        chk($sformatf("v%0d_done_cycle", id), cnt, v.t_done);
        chk($sformatf("v%0d_nbits", id), nb, v.nbits);
        chk($sformatf("v%0d_hits_ov", id), hov, v.hov);
        chk($sformatf("v%0d_hits_no", id), hno, v.hno);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{16'h000A, 5'd4,  4'd0, 4,  5,  1, 1};
        tbl[1] = '{16'h0055, 5'd7,  4'd0, 7,  8,  3, 2};
        tbl[2] = '{16'h0005, 5'd3,  4'd2, 9,  14, 3, 3};
        tbl[3] = '{16'hFFFF, 5'd0,  4'd1, 0,  1,  0, 0};
        tbl[4] = '{16'h8000, 5'd20, 4'd0, 16, 17, 0, 0};
        tbl[5] = '{16'h000A, 5'd4,  4'd1, 8,  11, 2, 2};
        tbl[6] = '{16'h0001, 5'd1,  4'd3, 4,  11, 0, 0};

        step();
        step();
        rst = 1'b1;
        step();

        for (int i = 0; i < 7; i++) do_run(tbl[i], i);

        // start pulsed while busy must not disturb the running stream
        drain();
        pattern = 16'h000A; len = 5'd4; repeat_cnt = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        pattern = 16'hFFFF; len = 5'd16; start = 1'b1;
        step(); step(); step();
        start = 1'b0;
        drain();

        // start held from the done cycle is taken one idle cycle later
        pattern = 16'h0005; len = 5'd3; repeat_cnt = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 50 && !a_done; i++) step();
        chk("b2b_done_seen", a_done, 1'b1);
        pattern = 16'h000D; len = 5'd4; start = 1'b1;
        step(); step(); step();
        start = 1'b0;
        drain();

        // asynchronous reset in the middle of SHIFT
        pattern = 16'hA000; len = 5'd16; repeat_cnt = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        #3;
        rst = 1'b0;
        #1;
        chk("rst_bit_out",   a_bit,   1'b0);
        chk("rst_bit_valid", a_valid, 1'b0);
        chk("rst_busy",      a_busy,  1'b0);
        chk("rst_done",      a_done,  1'b0);
        chk("rst_hit",       a_hit | b_hit, 1'b0);
        exp_q.delete();
        line_q.delete();
        last_hit_no = -100;
        cur_bit = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        do_run(tbl[0], 7);

        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            pattern = 16'($urandom);
            len = LW'($urandom_range(0, 20));
            repeat_cnt = 4'($urandom_range(0, 3));
            step();
        end
        start = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
